// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: instruction format codes, major opcodes and
// field positions that do not depend on XLEN.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;

  localparam int OPC_MSB   = 6;
  localparam int F3_MSB    = 14;
  localparam int F3_LSB    = 12;
  localparam int SHAMT_LSB = 20;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: insn -> {imm, fmt}, zero latency, no flow control.
// Shift-immediates return a zero-extended shamt so funct7/funct6 never reach the immediate.
module imm_decode
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     insn,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic [5:0]  shamt;
  logic        is_shift;

  assign op       = insn[OPC_MSB:0];
  assign f3       = insn[F3_MSB:F3_LSB];
  assign is_shift = (op == OP_IMM || op == OP_IMM32) && (f3 == F3_SLL || f3 == F3_SRL);

  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    shamt = '0;
    case (op)
      OP_IMM, OP_IMM32, LOAD, JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{insn[31]}}, insn[31:20]};
      end
      STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      end
      BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt   = FMT_U;
        imm32 = {insn[31:12], 12'b0};
      end
      JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase

    // Only RV64 OP-IMM shifts carry a 6-bit shamt; word shifts and RV32 use 5 bits.
    if (is_shift) begin
      fmt = FMT_SH;
      if (op == OP_IMM && XLEN == 64) shamt = insn[SHAMT_LSB+5:SHAMT_LSB];
      else                            shamt = {1'b0, insn[SHAMT_LSB+4:SHAMT_LSB]};
      imm = XLEN'(shamt);
    end else begin
      imm = XLEN'($signed(imm32));
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a 2-entry elastic buffer: 1-cycle latency, 1/cycle throughput.
// dinRetry rises only when both entries are full; the head holds steady while qRetry=1.
module imm_gen_pipe
  import rv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit PASS_INSN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     insn,
  input  logic            dinValid,
  output logic            dinRetry,
  output logic [XLEN-1:0] q_imm,
  output logic [2:0]      q_fmt,
  output logic [31:0]     q_insn,
  output logic            qValid,
  input  logic            qRetry
);

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .insn (insn),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  logic [XLEN-1:0] buf_imm  [2];
  fmt_t            buf_fmt  [2];
  logic [31:0]     buf_insn [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign push = dinValid && !dinRetry;
  assign pop  = qValid && !qRetry;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Payload storage needs no reset: the outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_imm[wr_ptr]  <= dec_imm;
      buf_fmt[wr_ptr]  <= dec_fmt;
      buf_insn[wr_ptr] <= PASS_INSN ? insn : 32'd0;
    end
  end

  assign qValid   = (count != 2'd0);
  assign dinRetry = (count == 2'd2);
  assign q_imm    = qValid ? buf_imm[rd_ptr] : '0;
  assign q_fmt    = qValid ? buf_fmt[rd_ptr] : FMT_NONE;
  assign q_insn   = qValid ? buf_insn[rd_ptr] : 32'd0;

endmodule
